// File: rtl/wb_mem_loader_if.sv
// rtl/wb_mem_loader_if.sv - Wishbone slave bus bundle for the program-memory loader
interface wb_mem_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_mem_loader.sv
// rtl/wb_mem_loader.sv - Wishbone loader for the 4x1024x16 program memory with CPU hold
// Optional write checksum register enabled by LOADER_CKSUM_EN.
module wb_mem_loader #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  wb_mem_loader_if.slave bus,
  input  logic [15:0] mem_data_i,
  output logic [15:0] mem_data_o,
  output logic [11:0] mem_addr_o,
  output logic        mem_rw_o,
  output logic        mem_en_o,
  output logic        cpu_hold_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  state_t     state;
  logic       hold;
  logic       err;
  logic [1:0] wait_cnt;

  logic selected, req, is_mem, is_ctrl, mem_ok;
  logic unused_bits;

  assign selected = bus.wbs_adr_i[31:15] == BASE_ADDR[31:15];
  assign req      = bus.wbs_stb_i & bus.wbs_cyc_i & selected;
  assign is_mem   = ~bus.wbs_adr_i[14];
  assign is_ctrl  = bus.wbs_adr_i[14] && (bus.wbs_adr_i[13:2] == 12'd0);
  // Only full 16-bit writes are legal; partial selects are flagged instead of issued.
  assign mem_ok   = hold && !(bus.wbs_we_i && (bus.wbs_sel_i[1:0] != 2'b11));

  assign cpu_hold_o  = hold;
  assign unused_bits = &{1'b0, bus.wbs_sel_i[3:2], bus.wbs_dat_i[31:16], bus.wbs_adr_i[1:0]};

`ifdef LOADER_CKSUM_EN
  logic [15:0] cksum;
  logic        is_cksum;
  assign is_cksum = bus.wbs_adr_i[14] && (bus.wbs_adr_i[13:2] == 12'd1);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state         <= IDLE;
      hold          <= 1'b0;
      err           <= 1'b0;
      wait_cnt      <= 2'd0;
      mem_data_o    <= 16'd0;
      mem_addr_o    <= 12'd0;
      mem_rw_o      <= 1'b0;
      mem_en_o      <= 1'b0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= 32'd0;
`ifdef LOADER_CKSUM_EN
      cksum         <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (is_mem) begin
              if (mem_ok) begin
                mem_addr_o <= bus.wbs_adr_i[13:2];
                mem_data_o <= bus.wbs_dat_i[15:0];
                mem_rw_o   <= bus.wbs_we_i;
                mem_en_o   <= 1'b1;
                state      <= ISSUE;
              end else begin
                err           <= 1'b1;
                bus.wbs_ack_o <= 1'b1;
                state         <= ACK;
                if (!bus.wbs_we_i) bus.wbs_dat_o <= 32'd0;
              end
            end else begin
              bus.wbs_ack_o <= 1'b1;
              state         <= ACK;
              if (bus.wbs_we_i) begin
                if (is_ctrl) begin
                  hold <= bus.wbs_dat_i[0];
                  if (bus.wbs_dat_i[1]) err <= 1'b0;
                end
`ifdef LOADER_CKSUM_EN
                if (is_cksum) cksum <= 16'd0;
`endif
              end else begin
                bus.wbs_dat_o <= is_ctrl ? {30'd0, err, hold} : 32'd0;
`ifdef LOADER_CKSUM_EN
                if (is_cksum) bus.wbs_dat_o <= {16'd0, cksum};
`endif
              end
            end
          end
        end
        ISSUE: begin
          mem_en_o <= 1'b0;
          wait_cnt <= 2'd0;
          if (mem_rw_o) begin
            bus.wbs_ack_o <= 1'b1;
            state         <= ACK;
`ifdef LOADER_CKSUM_EN
            cksum         <= cksum + mem_data_o;
`endif
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Bank data is valid READ_LATENCY cycles after the enable cycle.
          if (wait_cnt == LAST_WAIT) begin
            bus.wbs_dat_o <= {16'd0, mem_data_i};
            bus.wbs_ack_o <= 1'b1;
            state         <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ACK: begin
          bus.wbs_ack_o <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_loader.sv
// tb/tb_wb_mem_loader.sv - randomized model-checked bench for wb_mem_loader
module tb_wb_mem_loader;
  localparam int RL = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_mem_loader_if bus();
  logic [15:0] mem_rdata = 16'd0;
  logic [15:0] mem_wdata;
  logic [11:0] mem_addr;
  logic        mem_rw, mem_en, cpu_hold;

  wb_mem_loader #(.BASE_ADDR(BASE), .READ_LATENCY(RL)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .bus(bus.slave),
    .mem_data_i(mem_rdata), .mem_data_o(mem_wdata), .mem_addr_o(mem_addr),
    .mem_rw_o(mem_rw), .mem_en_o(mem_en), .cpu_hold_o(cpu_hold)
  );

  int tot = 0;
  int bad = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic        m_hold = 1'b0, m_err = 1'b0;
  logic [15:0] m_ck = 16'd0;
  logic [15:0] ref_mem [4096];
  logic [15:0] bank_mem [4096];
  int          exp_ack_cyc = -1, exp_en_cyc = -1;
  logic [11:0] exp_addr = 12'd0;
  logic [15:0] exp_wdata = 16'd0;
  logic        exp_rw = 1'b0, exp_is_read = 1'b0, exp_hold_v = 1'b0;
  logic [31:0] exp_rdat = 32'd0, m_last_dat = 32'd0;
  logic [11:0] seen_addr = 12'd0;
  logic [15:0] seen_data = 16'd0;
  logic        seen_rw = 1'b0;
  int          rd_due = -1;
  logic [15:0] rd_val = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Compare process plus the bank-side memory responder.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ack", {31'd0, bus.wbs_ack_o}, {31'd0, cyc_n == exp_ack_cyc});
        chk("mem_en", {31'd0, mem_en}, {31'd0, cyc_n == exp_en_cyc});
        if (mem_en) begin
          chk("mem_addr", {20'd0, mem_addr}, {20'd0, exp_addr});
          chk("mem_data", {16'd0, mem_wdata}, {16'd0, exp_wdata});
          chk("mem_rw", {31'd0, mem_rw}, {31'd0, exp_rw});
          seen_addr = mem_addr; seen_data = mem_wdata; seen_rw = mem_rw;
          if (mem_rw) bank_mem[mem_addr] = mem_wdata;
          else begin rd_due = cyc_n + RL; rd_val = bank_mem[mem_addr]; end
        end
        if (bus.wbs_ack_o) chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, exp_hold_v});
        if (bus.wbs_ack_o && exp_is_read) begin
          chk("rdata", bus.wbs_dat_o, exp_rdat);
          m_last_dat = exp_rdat;
        end else begin
          chk("dat_stable", bus.wbs_dat_o, m_last_dat);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = (cyc_n == rd_due) ? rd_val : 16'($urandom);
    end
  end

  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    int c;
    logic [14:0] off;
    logic got;
    @(posedge clk); #1;
    c = cyc_n;
    off = adr[14:0];
    exp_is_read = !we;
    exp_rdat = 32'd0;
    if (!off[14]) begin
      if (m_hold && !(we && sel[1:0] != 2'b11)) begin
        exp_en_cyc = c + 1; exp_addr = off[13:2]; exp_wdata = dat[15:0]; exp_rw = we;
        if (we) begin
          ref_mem[off[13:2]] = dat[15:0];
          m_ck = m_ck + dat[15:0];
          exp_ack_cyc = c + 2;
        end else begin
          exp_rdat = {16'd0, ref_mem[off[13:2]]};
          exp_ack_cyc = c + 2 + RL;
        end
      end else begin
        m_err = 1'b1;
        exp_ack_cyc = c + 1;
      end
    end else begin
      exp_ack_cyc = c + 1;
      if (off[13:2] == 12'd0) begin
        if (we) begin
          m_hold = dat[0];
          if (dat[1]) m_err = 1'b0;
        end else exp_rdat = {30'd0, m_err, m_hold};
      end else if (off[13:2] == 12'd1) begin
`ifdef LOADER_CKSUM_EN
        if (we) m_ck = 16'd0;
        else exp_rdat = {16'd0, m_ck};
`endif
      end
    end
    exp_hold_v = m_hold;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin got = 1'b1; break; end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    rdat = bus.wbs_dat_o;
    lat = cyc_n - c;
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic unsel(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    @(posedge clk); #1;
    exp_ack_cyc = -1; exp_en_cyc = -1;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"}, {31'd0, bus.wbs_ack_o}, 32'd0);
    chk({tag, "_dat"}, bus.wbs_dat_o, 32'd0);
    chk({tag, "_mem"}, {3'd0, mem_en, mem_rw, mem_addr, mem_wdata}, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d, a;
    int lat, r;
    for (int i = 0; i < 4096; i++) begin ref_mem[i] = 16'd0; bank_mem[i] = 16'd0; end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = 32'd0; bus.wbs_adr_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    access(1'b0, BASE | 32'h4000, 32'd0, 4'hF, rd, lat);
    chk("ctrl_after_reset", rd, 32'd0);
    chk("reg_latency", lat, 1);

    access(1'b1, BASE | 32'h4000, 32'h1, 4'hF, rd, lat);
    access(1'b1, BASE | 32'h2010, 32'h0000_A5C3, 4'hF, rd, lat);
    chk("wr_latency", lat, 2);
    chk("wr_addr", {20'd0, seen_addr}, 32'h804);
    chk("wr_data", {16'd0, seen_data}, 32'hA5C3);
    chk("wr_rw", {31'd0, seen_rw}, 32'd1);

    access(1'b0, BASE | 32'h2010, 32'd0, 4'hF, rd, lat);
    chk("rd_latency", lat, 4);
    chk("rd_data", rd, 32'h0000_A5C3);
    chk("rd_rw", {31'd0, seen_rw}, 32'd0);

    access(1'b1, BASE | 32'h4000, 32'h0, 4'hF, rd, lat);
    access(1'b1, BASE | 32'h0000, 32'h1234, 4'hF, rd, lat);
    chk("nohold_latency", lat, 1);
    access(1'b0, BASE | 32'h4000, 32'd0, 4'hF, rd, lat);
    chk("err_set", rd, 32'h2);
    access(1'b1, BASE | 32'h4000, 32'h2, 4'hF, rd, lat);
    access(1'b0, BASE | 32'h4000, 32'd0, 4'hF, rd, lat);
    chk("err_clear", rd, 32'h0);

    access(1'b1, BASE | 32'h4000, 32'h1, 4'hF, rd, lat);
    access(1'b1, BASE | 32'h0100, 32'h5555, 4'h1, rd, lat);
    chk("partial_latency", lat, 1);
    access(1'b0, BASE | 32'h4000, 32'd0, 4'hF, rd, lat);
    chk("partial_err", rd, 32'h3);
    access(1'b1, BASE | 32'h4000, 32'h3, 4'hF, rd, lat);
    unsel(1'b1, 32'h3000_C000, 32'h0);
    access(1'b0, BASE | 32'h4000, 32'd0, 4'hF, rd, lat);
    chk("unsel_no_effect", rd, 32'h1);

    access(1'b1, BASE | 32'h4004, 32'd0, 4'hF, rd, lat);
    access(1'b1, BASE | 32'h0008, 32'hFFFF, 4'hF, rd, lat);
    access(1'b1, BASE | 32'h000C, 32'h0002, 4'hF, rd, lat);
    access(1'b0, BASE | 32'h4004, 32'd0, 4'hF, rd, lat);
`ifdef LOADER_CKSUM_EN
    chk("cksum_sum", rd, 32'h1);
`else
    chk("cksum_absent", rd, 32'h0);
`endif
    access(1'b1, BASE | 32'h4004, 32'd0, 4'hF, rd, lat);
    access(1'b0, BASE | 32'h4004, 32'd0, 4'hF, rd, lat);
    chk("cksum_clear", rd, 32'h0);
    access(1'b0, BASE | 32'h5000, 32'd0, 4'hF, rd, lat);
    chk("other_reg", rd, 32'h0);

    // Reset while the read sits in WAIT: no ack, everything back to zero.
    @(posedge clk); #1;
    r = cyc_n;
    exp_en_cyc = r + 1; exp_addr = 12'h804; exp_wdata = 16'h0; exp_rw = 1'b0;
    exp_ack_cyc = -1; exp_is_read = 1'b1;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE | 32'h2010; bus.wbs_dat_i = 32'd0; bus.wbs_sel_i = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
    m_hold = 1'b0; m_err = 1'b0; m_ck = 16'd0; m_last_dat = 32'd0;
    chk_zero_outputs("midwait_reset");
    rst_n = 1'b1;
    repeat (RL + 3) @(posedge clk);
    access(1'b0, BASE | 32'h4000, 32'd0, 4'hF, rd, lat);
    chk("ctrl_after_midreset", rd, 32'h0);
    access(1'b1, BASE | 32'h4000, 32'h1, 4'hF, rd, lat);
    access(1'b0, BASE | 32'h2010, 32'd0, 4'hF, rd, lat);
    chk("rd_after_reset", rd, 32'h0000_A5C3);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 55) begin
        a = BASE | {17'd0, 1'b0, 2'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 2'($urandom)};
        access(1'($urandom), a, d, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF, rd, lat);
      end else if (r < 70) begin
        d[0] = ($urandom_range(0, 4) != 0);
        access(1'b1, BASE | 32'h4000, d, 4'hF, rd, lat);
      end else if (r < 80) begin
        access(1'b0, BASE | 32'h4000, d, 4'hF, rd, lat);
      end else if (r < 87) begin
        access($urandom_range(0, 4) == 0, BASE | 32'h4004, d, 4'hF, rd, lat);
      end else if (r < 93) begin
        a = BASE | (32'h4008 + 32'(4 * $urandom_range(0, 4093)));
        access(1'($urandom), a, d, 4'hF, rd, lat);
      end else begin
        unsel(1'($urandom), 32'h3000_8000 | 32'($urandom_range(0, 32767)), d);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
